stream_packer: RTL
==================

Name: stream_packer

Overview:
- Narrow-to-wide AXI-Stream width up-converter. Packs RATIO consecutive narrow input beats into one wide output word.
- Sits directly upstream of the funnel and produces the wide words it consumes; also serves as the generic gather stage on the ingest path.
- A packet ending mid-word (input last) is flushed as a zero-padded partial word with last set.

Parameters:
- LSB_FIRST, 1, 1 = first accepted beat lands in bits [IN_W-1:0] of the output; 0 = first beat lands in the top lane [OUT_W-1:OUT_W-IN_W].
- Derived localparams: IN_W = packer_in.DATA_WIDTH; OUT_W = packer_out.DATA_WIDTH; RATIO = OUT_W/IN_W.
- Elaboration check: OUT_W % IN_W == 0 and RATIO >= 2; otherwise $fatal.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- packer_in  axi_stream_if.slave  IN_W  narrow input stream (data, valid, ready, last).
- packer_out  axi_stream_if.master  OUT_W  wide output stream (data, valid, ready, last).
- packer_out_lanes  output  $clog2(RATIO)+1  number of valid lanes in the current output word; present only with the optional feature.

Behaviour:
- Reset: clk and rst_n are the only clock/reset. Reset is synchronous, active-low.
  - While rst_n=0: lane counter, out_valid_r, out_last_r and acc_r are cleared.
  - packer_out.valid=0, packer_out.last=0, packer_out.data=0, packer_in.ready=0.
  - Reset asserted mid-word discards the partial accumulation; nothing is emitted.
- Registers:
  - acc_r [OUT_W]: accumulator.
  - cnt_r [$clog2(RATIO)]: next lane index.
  - Output holding register: out_data_r, out_last_r, out_valid_r.
- Handshakes:
  - in_fire = packer_in.valid && packer_in.ready.
  - out_fire = packer_out.valid && packer_out.ready.
  - packer_in.ready = rst_n && (!out_valid_r || packer_out.ready).
  - ready never depends on packer_in.valid or packer_in.last.
- On in_fire:
  - Write data into lane cnt_r (lane index mirrored to RATIO-1-cnt_r when LSB_FIRST=0).
  - Word completes if cnt_r==RATIO-1 or packer_in.last==1.
  - Complete: load out_data_r with the merged word, with unwritten lanes forced to 0. Set out_last_r = packer_in.last and out_valid_r = 1. Clear acc_r to 0 and cnt_r to 0.
  - Not complete: acc_r lane updated, cnt_r += 1.
- out_valid_r: cleared on out_fire unless a new word completes in the same cycle. Simultaneous out_fire plus completion reloads the holding register with no bubble.
- Output mapping: packer_out.valid/data/last = out_valid_r/out_data_r/out_last_r. Data and last are stable while valid && !ready.
- Latency: word is visible on packer_out one cycle after its final input beat is accepted.
- Throughput: one input beat per cycle while the output drains. Sustained: 1 output word per RATIO cycles.
- Backpressure: while out_valid_r && !packer_out.ready, packer_in.ready=0 and no lanes are accumulated. No data is lost or reordered.
- last on a beat with cnt_r==RATIO-1 produces a full word with last=1; no extra empty word follows.
- A beat with last=1 at cnt_r==0 produces a single-lane word.
- cnt_r wraps to 0 only via completion and never reaches RATIO.

Optional Feature:
- Macro: STREAM_PACKER_LANES_EN.
- Defined: port packer_out_lanes exists.
  - Registered alongside out_data_r as (cnt_r+1) at the completing beat, i.e. 1..RATIO.
  - Reset value 0. Held stable under backpressure.
- Undefined: port and register absent; all other behaviour identical.

Test Plan:
- IN_W=8, OUT_W=32, LSB_FIRST=1, out.ready=1; beats 0x11,0x22,0x33,0x44 on consecutive cycles -> one cycle after 0x44: out.data=0x44332211, last=0, lanes=4, valid for exactly 1 cycle.
- Beats 0xAA, then 0xBB with last=1 -> out.data=0x0000BBAA, last=1, lanes=2. Next word starts at lane 0 (0xCC,0xDD,0xEE,0xFF -> 0xFFEEDDCC).
- LSB_FIRST=0, beats 0x11,0x22,0x33,0x44 -> out.data=0x11223344. Single beat 0x5A with last -> 0x5A000000, lanes=1.
- Word 0x44332211 pending, out.ready=0 for 5 cycles -> data stable, in.ready=0 throughout. Release -> following 4 beats produce 0x88776655, no loss or duplication.
- Continuous 64 random beats with out.ready=1 -> in.ready never drops, 16 words out, scoreboard match, last only on the final word.
- Beats 0x01,0x02 accepted, then rst_n=0 for 2 cycles -> no output word, valid=0, ready=0 during reset. After release, beats 0x03..0x06 -> 0x06050403.

Source files
------------

// File: rtl/stream_packer_if.sv
// AXI-Stream style interface: data, valid, ready, last.
// Master drives the payload, slave drives ready.
interface axi_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  last;

  modport master (
    output data,
    output valid,
    output last,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  last,
    output ready
  );
endinterface

// File: rtl/stream_packer.sv
// Narrow-to-wide AXI-Stream packer: RATIO input beats form one output word.
// Optional STREAM_PACKER_LANES_EN adds packer_out_lanes (valid lane count).
module stream_packer #(
  parameter bit LSB_FIRST = 1'b1,
  parameter int LANES_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  axi_stream_if.slave        packer_in,
  axi_stream_if.master       packer_out
`ifdef STREAM_PACKER_LANES_EN
  ,
  output logic [LANES_W-1:0] packer_out_lanes
`endif
);

  localparam int IN_W  = $bits(packer_in.data);
  localparam int OUT_W = $bits(packer_out.data);
  localparam int RATIO = OUT_W / IN_W;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  if ((OUT_W % IN_W) != 0 || RATIO < 2) begin : g_bad_ratio
    $fatal(1, "stream_packer: OUT_W must be a multiple of IN_W, ratio >= 2");
  end

`ifdef STREAM_PACKER_LANES_EN
  if (LANES_W != $clog2(RATIO) + 1) begin : g_bad_lanes
    $fatal(1, "stream_packer: LANES_W must equal clog2(RATIO)+1");
  end
`endif

  logic [OUT_W-1:0] acc_q;
  logic [OUT_W-1:0] acc_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [OUT_W-1:0] out_data_q;
  logic [OUT_W-1:0] out_data_d;
  logic             out_valid_q;
  logic             out_valid_d;
  logic             out_last_q;
  logic             out_last_d;

`ifdef STREAM_PACKER_LANES_EN
  logic [LANES_W-1:0] lanes_q;
  logic [LANES_W-1:0] lanes_d;
`endif

  logic             in_ready;
  logic             in_fire;
  logic             out_fire;
  logic             word_done;
  logic [CW-1:0]    lane;
  logic [OUT_W-1:0] merged;

  // Ready is a function of the holding register and downstream only.
  assign in_ready  = rst_n && (!out_valid_q || packer_out.ready);
  assign in_fire   = packer_in.valid && in_ready;
  assign out_fire  = out_valid_q && packer_out.ready;
  assign word_done = (cnt_q == LAST_LANE) || packer_in.last;
  assign lane      = LSB_FIRST ? cnt_q : (LAST_LANE - cnt_q);

  always_comb begin
    merged = acc_q;
    for (int i = 0; i < RATIO; i++) begin
      if (lane == CW'(i)) begin
        merged[i*IN_W +: IN_W] = packer_in.data;
      end
    end
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
`ifdef STREAM_PACKER_LANES_EN
    lanes_d     = lanes_q;
`endif

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (in_fire) begin
      if (word_done) begin
        out_data_d  = merged;
        out_last_d  = packer_in.last;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
`ifdef STREAM_PACKER_LANES_EN
        lanes_d     = LANES_W'(cnt_q) + LANES_W'(1);
`endif
      end else begin
        acc_d = merged;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef STREAM_PACKER_LANES_EN
      lanes_q     <= '0;
`endif
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
`ifdef STREAM_PACKER_LANES_EN
      lanes_q     <= lanes_d;
`endif
    end
  end

  assign packer_in.ready  = in_ready;
  assign packer_out.valid = out_valid_q;
  assign packer_out.data  = out_data_q;
  assign packer_out.last  = out_last_q;
`ifdef STREAM_PACKER_LANES_EN
  assign packer_out_lanes = lanes_q;
`endif

endmodule
